// File: rtl/window_peak_detector.sv
// Tracks the maximum sample (and its index) over a window of win_len_i samples,
// then holds the result until consumed. Define WINDOW_PEAK_DETECTOR_MIN_TRACK_EN to add minimum tracking.
//
// state   | meaning
// ACCUM   | accepting samples, updating peak registers
// HOLD    | window complete, result presented until peak_ready_i
module window_peak_detector #(
    parameter int DATA_WIDTH = 13,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clear_i,
    input  logic [CNT_WIDTH-1:0]  win_len_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    output logic [DATA_WIDTH-1:0] peak_o,
    output logic [CNT_WIDTH-1:0]  peak_idx_o,
    output logic                  peak_valid_o,
`ifdef WINDOW_PEAK_DETECTOR_MIN_TRACK_EN
    output logic [DATA_WIDTH-1:0] min_o,
    output logic [CNT_WIDTH-1:0]  min_idx_o,
`endif
    input  logic                  peak_ready_i
);

    typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [DATA_WIDTH-1:0] peak_q, peak_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic                  first;
    logic [CNT_WIDTH-1:0]  len_eff;
    logic [CNT_WIDTH-1:0]  cnt_inc;
`ifdef WINDOW_PEAK_DETECTOR_MIN_TRACK_EN
    logic [DATA_WIDTH-1:0] min_q, min_d;
    logic [CNT_WIDTH-1:0]  min_idx_q, min_idx_d;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            len_q   <= '0;
            peak_q  <= '0;
            idx_q   <= '0;
`ifdef WINDOW_PEAK_DETECTOR_MIN_TRACK_EN
            min_q     <= '0;
            min_idx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            peak_q  <= peak_d;
            idx_q   <= idx_d;
`ifdef WINDOW_PEAK_DETECTOR_MIN_TRACK_EN
            min_q     <= min_d;
            min_idx_q <= min_idx_d;
`endif
        end
    end

    // Length is sampled on the first sample only; a zero length means one sample.
    always_comb begin
        first   = (cnt_q == '0);
        len_eff = len_q;
        if (first) begin
            len_eff = (win_len_i == '0) ? CNT_WIDTH'(1) : win_len_i;
        end
        cnt_inc = cnt_q + CNT_WIDTH'(1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        peak_d  = peak_q;
        idx_d   = idx_q;
`ifdef WINDOW_PEAK_DETECTOR_MIN_TRACK_EN
        min_d     = min_q;
        min_idx_d = min_idx_q;
`endif
        if (clear_i) begin
            state_d = ST_ACCUM;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (data_valid_i) begin
                        len_d = len_eff;
                        cnt_d = cnt_inc;
                        if (first || (data_i > peak_q)) begin
                            peak_d = data_i;
                            idx_d  = cnt_q;
                        end
`ifdef WINDOW_PEAK_DETECTOR_MIN_TRACK_EN
                        if (first || (data_i < min_q)) begin
                            min_d     = data_i;
                            min_idx_d = cnt_q;
                        end
`endif
                        if (cnt_inc == len_eff) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (peak_ready_i) begin
                        state_d = ST_ACCUM;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign data_ready_o = (state_q == ST_ACCUM);
    assign peak_valid_o = (state_q == ST_HOLD);
    assign peak_o       = peak_q;
    assign peak_idx_o   = idx_q;
`ifdef WINDOW_PEAK_DETECTOR_MIN_TRACK_EN
    assign min_o        = min_q;
    assign min_idx_o    = min_idx_q;
`endif

endmodule

// File: doc/window_peak_detector.md
WINDOW_PEAK_DETECTOR -- requirements
Module: window_peak_detector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 13, sample width in bits (unsigned).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the window-length and index fields.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous abort of the current window.
REQ-006 SHALL have port win_len_i  input  CNT_WIDTH  samples per window (unsigned).
REQ-007 SHALL have port data_i  input  DATA_WIDTH  sample value.
REQ-008 SHALL have port data_valid_i  input  1  sample present on data_i.
REQ-009 SHALL have port data_ready_o  output  1  block can accept a sample.
REQ-010 SHALL have port peak_o  output  DATA_WIDTH  maximum of the completed window.
REQ-011 SHALL have port peak_idx_o  output  CNT_WIDTH  zero-based position of that maximum in the window.
REQ-012 SHALL have port peak_valid_o  output  1  result on peak_o/peak_idx_o is valid.
REQ-013 SHALL have port peak_ready_i  input  1  downstream consumes the result.

Function
REQ-014 SHALL implement two states: ACCUM (data_ready_o=1, peak_valid_o=0) and HOLD (data_ready_o=0, peak_valid_o=1).
REQ-015 SHALL accept a sample only when data_valid_i=1 and data_ready_o=1 in the same cycle.
REQ-016 SHALL latch win_len_i on the first accepted sample of each window; a latched value of 0 SHALL be treated as 1.
REQ-017 SHALL load the first accepted sample of a window and index 0 into the peak registers unconditionally.
REQ-018 SHALL replace the peak and index with a later sample only when that sample is strictly greater than the held peak (unsigned); ties SHALL keep the earliest index.
REQ-019 SHALL increment the sample counter by one per accepted sample; the counter SHALL never wrap within a window.
REQ-020 SHALL go from ACCUM to HOLD in the cycle after the sample that brings the accepted count to the latched length, with peak_o/peak_idx_o reflecting that sample's comparison.
REQ-021 SHALL hold peak_o, peak_idx_o and peak_valid_o stable in HOLD until peak_ready_i=1.
REQ-022 SHALL go from HOLD to ACCUM in the cycle after peak_valid_o=1 and peak_ready_i=1, with the counter reset to 0; no sample is accepted in the transfer cycle.
REQ-023 SHALL give clear_i priority over all other events: next state ACCUM, counter 0, peak_valid_o=0, and any sample offered in that cycle discarded.
REQ-024 SHALL not change win_len_i's effect mid-window; changes apply from the next window start.

Reset
REQ-025 SHALL while rstn_i=0 force state ACCUM, counter 0, peak_o=0, peak_idx_o=0, peak_valid_o=0, data_ready_o=1.
REQ-026 SHALL abandon any partial window or held result on reset assertion, regardless of state.

Configuration
REQ-027 SHALL, when macro WINDOW_PEAK_DETECTOR_MIN_TRACK_EN is defined, add outputs min_o (DATA_WIDTH) and min_idx_o (CNT_WIDTH) giving the window minimum and its index. The minimum is replaced only on a strictly-smaller sample, ties keep the earliest index, outputs are valid and stable together with peak_valid_o, and they reset to 0.
REQ-028 SHALL, when WINDOW_PEAK_DETECTOR_MIN_TRACK_EN is undefined, omit min_o, min_idx_o and all minimum logic; the remaining behaviour is identical.

Verification
REQ-029 SHALL cover: win_len_i=4, samples 5,9,3,7 -> peak_valid_o=1 one cycle after the 4th sample, peak_o=9, peak_idx_o=1 (min build: min_o=3, min_idx_o=2).
REQ-030 SHALL cover ties: win_len_i=3, samples 8,8,2 -> peak_o=8, peak_idx_o=0.
REQ-031 SHALL cover backpressure: peak_ready_i=0 for 5 cycles in HOLD with data_valid_i=1 -> outputs stable, data_ready_o=0, no sample consumed; peak_ready_i=1 -> ACCUM next cycle.
REQ-032 SHALL cover a zero-length window: win_len_i=0, sample 0x1FFF -> peak_o=0x1FFF, peak_idx_o=0 after a single sample.
REQ-033 SHALL cover clear: clear_i=1 after 2 of 4 samples (values 10,20), then 1,2,3,4 -> peak_o=4, peak_idx_o=3.
REQ-034 SHALL cover reset: rstn_i=0 asserted asynchronously in HOLD -> peak_valid_o=0 and data_ready_o=1 immediately, all outputs 0.
